counting_seq: RTL and testbench



---
 rtl/counting_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/counting_seq.sv | 84 ++++++++
 tb/tb_counting_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/counting_pkg.sv
// Shared defaults and helpers for the counting_seq sequence detector.
package counting_pkg;

    localparam int unsigned DEF_W       = 2;
    localparam int unsigned DEF_N       = 4;
    // Symbols 1,2,3,3 with symbol 0 in the least significant slot.
    localparam logic [7:0]  DEF_PATTERN = 8'hF9;

    // Width of the fill counter: enough to hold N-1 with headroom.
    function automatic int unsigned fill_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] q
);

    localparam logic [CW-1:0] MAX = '1;

    // Count up on inc, holding at all-ones; clr wins over inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/counting_seq.sv
// Streaming detector: pulses ans when the last N accepted symbols equal PATTERN.
module counting_seq
    import counting_pkg::*;
#(
    parameter int unsigned    W       = DEF_W,
    parameter int unsigned    N       = DEF_N,
    parameter logic [N*W-1:0] PATTERN = (N*W)'(DEF_PATTERN),
    parameter int unsigned    OVERLAP = 1,
    parameter int unsigned    CW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          valid,
    input  logic [W-1:0]  num,
    output logic          ans,
    output logic [CW-1:0] match_cnt
);

    localparam int unsigned    FW       = fill_width(N);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

    logic [FW-1:0]  fill;
    logic [N*W-1:0] window;
    logic           hit;

    generate
        if (N == 1) begin : g_no_hist
            assign window = num;
        end else begin : g_hist
            // Oldest symbol sits in the low slot, newest in the high slot.
            logic [(N-1)*W-1:0] hist;
            logic [N*W-1:0]     shifted;

            assign window  = {num, hist};
            assign shifted = window >> W;

            // Shift each accepted symbol in at the top, dropping the oldest.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    hist <= '0;
                end else if (clear) begin
                    hist <= '0;
                end else if (valid) begin
                    hist <= shifted[(N-1)*W-1:0];
                end
            end
        end
    endgenerate

    // fill gating keeps stale or zeroed history from ever matching.
    assign hit = valid & ~clear & (fill >= FILL_MAX) & (window == PATTERN);

    // Track how many symbols are in the history and register the match pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill <= '0;
            ans  <= 1'b0;
        end else if (clear) begin
            fill <= '0;
            ans  <= 1'b0;
        end else if (!valid) begin
            ans  <= 1'b0;
        end else begin
            ans <= hit;
            if (hit && (OVERLAP == 0)) begin
                fill <= '0;
            end else if (fill < FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (hit),
        .q     (match_cnt)
    );

endmodule

// File: tb/tb_counting_seq.sv
// Scoreboard bench: four detector configurations share one stimulus stream.
module tb_counting_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       valid;
    logic [1:0] num;

    logic       ans0, ans1, ans2, ans3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    always #5 clk = ~clk;

    // 0: defaults; 1: N=3 ones overlap; 2: N=3 ones non-overlap; 3: defaults with CW=2
    counting_seq dut0 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .num(num),
        .ans(ans0), .match_cnt(cnt0)
    );
    counting_seq #(.W(2), .N(3), .PATTERN(6'h15), .OVERLAP(1), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .num(num),
        .ans(ans1), .match_cnt(cnt1)
    );
    counting_seq #(.W(2), .N(3), .PATTERN(6'h15), .OVERLAP(0), .CW(8)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .num(num),
        .ans(ans2), .match_cnt(cnt2)
    );
    counting_seq #(.W(2), .N(4), .PATTERN(8'hF9), .OVERLAP(1), .CW(2)) dut3 (
        .clk(clk), .reset(reset), .clear(clear), .valid(valid), .num(num),
        .ans(ans3), .match_cnt(cnt3)
    );

    // Reference model parameters per instance.
    localparam int NN   [4] = '{4, 3, 3, 4};
    localparam int PATV [4] = '{32'hF9, 32'h15, 32'h15, 32'hF9};
    localparam int OV   [4] = '{1, 1, 0, 1};
    localparam int CWV  [4] = '{8, 8, 8, 2};

    typedef struct packed {
        logic [3:0] ans;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: recent accepted symbols (index 0 newest), count since flush.
    int m_last [4][8];
    int m_len  [4];
    int m_cnt  [4];
    bit m_ans  [4];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_len[i] = 0;
            m_cnt[i] = 0;
            m_ans[i] = 1'b0;
            for (int k = 0; k < 8; k++) m_last[i][k] = 0;
        end
    endtask

    task automatic model_step(input bit c, input bit v, input int n);
        bit match;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                m_len[i] = 0;
                m_cnt[i] = 0;
                m_ans[i] = 1'b0;
            end else if (!v) begin
                m_ans[i] = 1'b0;
            end else begin
                for (int k = 7; k > 0; k--) m_last[i][k] = m_last[i][k-1];
                m_last[i][0] = n;
                if (m_len[i] < 16) m_len[i]++;
                match = (m_len[i] >= NN[i]);
                for (int k = 0; k < NN[i]; k++) begin
                    if (m_last[i][k] != ((PATV[i] >> ((NN[i] - 1 - k) * 2)) & 3)) match = 1'b0;
                end
                m_ans[i] = match;
                if (match) begin
                    if (m_cnt[i] < (1 << CWV[i]) - 1) m_cnt[i]++;
                    if (OV[i] == 0) m_len[i] = 0;
                end
            end
        end
    endtask

    // Drive one cycle; the expectation is queued once the edge has happened.
    task automatic cycle(input bit c, input bit v, input int n);
        exp_t e;
        clear = c;
        valid = v;
        num   = 2'(n);
        model_step(c, v, n);
        for (int i = 0; i < 4; i++) e.ans[i] = m_ans[i];
        e.c0 = 8'(m_cnt[0]);
        e.c1 = 8'(m_cnt[1]);
        e.c2 = 8'(m_cnt[2]);
        e.c3 = 8'(m_cnt[3]);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic feed(input int s0, input int s1, input int s2, input int s3);
        cycle(1'b0, 1'b1, s0);
        cycle(1'b0, 1'b1, s1);
        cycle(1'b0, 1'b1, s2);
        cycle(1'b0, 1'b1, s3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " ans0"}, int'(ans0), 0);
        chk({tag, " ans1"}, int'(ans1), 0);
        chk({tag, " ans2"}, int'(ans2), 0);
        chk({tag, " ans3"}, int'(ans3), 0);
        chk({tag, " cnt0"}, int'(cnt0), 0);
        chk({tag, " cnt1"}, int'(cnt1), 0);
        chk({tag, " cnt2"}, int'(cnt2), 0);
        chk({tag, " cnt3"}, int'(cnt3), 0);
    endtask

    // Assert reset between edges and confirm outputs drop before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Monitor: outputs are presented every cycle, compare against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ans0", int'(ans0), int'(e.ans[0]));
            chk("ans1", int'(ans1), int'(e.ans[1]));
            chk("ans2", int'(ans2), int'(e.ans[2]));
            chk("ans3", int'(ans3), int'(e.ans[3]));
            chk("cnt0", int'(cnt0), int'(e.c0));
            chk("cnt1", int'(cnt1), int'(e.c1));
            chk("cnt2", int'(cnt2), int'(e.c2));
            chk("cnt3", int'(cnt3), int'(e.c3));
        end
    end

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        valid = 1'b0;
        num   = 2'd0;
        model_reset();
        #1 check_all_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic match followed by a non-matching symbol.
        feed(1, 2, 3, 3);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);

        // Gap in valid inside a partial match.
        cycle(1'b0, 1'b1, 1);
        cycle(1'b0, 1'b1, 2);
        for (int g = 0; g < 3; g++) cycle(1'b0, 1'b0, $urandom_range(0, 3));
        cycle(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b1, 3);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);

        // Constant pattern: overlap vs non-overlap.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1);
        cycle(1'b1, 1'b0, 0);

        // Clear with valid high discards progress and the symbol itself.
        cycle(1'b0, 1'b1, 1);
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, 3);
        cycle(1'b1, 1'b1, 3);
        cycle(1'b0, 1'b1, 3);
        feed(1, 2, 3, 3);
        cycle(1'b1, 1'b0, 0);

        // Saturation on the 2-bit counter.
        for (int r = 0; r < 5; r++) feed(1, 2, 3, 3);
        cycle(1'b0, 1'b0, 0);

        // Async reset while ans is high, then mid-sequence.
        feed(1, 2, 3, 3);
        async_reset();
        cycle(1'b0, 1'b1, 1);
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, 3);
        async_reset();
        cycle(1'b0, 1'b1, 3);
        feed(1, 2, 3, 3);

        // Random traffic.
        for (int t = 0; t < 2000; t++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3));
        end
        cycle(1'b0, 1'b0, 0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
